// File: rtl/kcounter_loop_filter.sv
// ADPLL loop filter: random-walk K-counter emitting Carry/Borrow to the DCO, plus a debounced lock qualifier.
// Latency: Carry/Borrow/KCount/Locked register one posedge after the sampled input; no backpressure (always accepts).
module kcounter_loop_filter #(
  parameter int KWIDTH     = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic              MainClock,
  input  logic              ResetN,
  input  logic              Enable,
  input  logic              Lead,
  input  logic              Lag,
  input  logic              Lock,
  input  logic              InputSignalEdge,
  output logic              Carry,
  output logic              Borrow,
  output logic              Locked,
  output logic [KWIDTH-1:0] KCount
);

  localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [KWIDTH-1:0] K_MID = KWIDTH'(1) << (KWIDTH - 1);
  localparam logic [KWIDTH-1:0] K_TOP = {KWIDTH{1'b1}};
  localparam logic [KWIDTH-1:0] K_BOT = '0;

  localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
  localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_CNT - 1);

  localparam logic [0:0] ST_ACQUIRE = 1'b0;
  localparam logic [0:0] ST_LOCKED  = 1'b1;

  logic [KWIDTH-1:0] kcount_nxt;
  logic              carry_nxt;
  logic              borrow_nxt;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [RUN_W-1:0]  lock_run;
  logic [RUN_W-1:0]  lock_run_nxt;
  logic [RUN_W-1:0]  miss_run;
  logic [RUN_W-1:0]  miss_run_nxt;

  logic step_up;
  logic step_dn;
  logic run_clr;

  // Conflicting or absent comparator pulses leave the counter alone.
  assign step_up = Lag & ~Lead;
  assign step_dn = Lead & ~Lag;

  // Disable behaves exactly like reset, re-applied every cycle.
  assign run_clr = ~ResetN | ~Enable;

  always_comb begin
    kcount_nxt = KCount;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;
    if (step_up) begin
      if (KCount == K_TOP) begin
        kcount_nxt = K_MID;
        carry_nxt  = 1'b1;
      end else begin
        kcount_nxt = KCount + KWIDTH'(1);
      end
    end else if (step_dn) begin
      if (KCount == K_BOT) begin
        kcount_nxt = K_MID;
        borrow_nxt = 1'b1;
      end else begin
        kcount_nxt = KCount - KWIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_run_nxt = lock_run;
    miss_run_nxt = miss_run;
    if (InputSignalEdge) begin
      if (state == ST_ACQUIRE) begin
        if (Lock) begin
          if (lock_run == LOCK_LAST) begin
            state_nxt    = ST_LOCKED;
            lock_run_nxt = '0;
            miss_run_nxt = '0;
          end else begin
            lock_run_nxt = lock_run + RUN_W'(1);
          end
        end else begin
          lock_run_nxt = '0;
        end
      end else begin
        if (!Lock) begin
          if (miss_run == UNLOCK_LAST) begin
            state_nxt    = ST_ACQUIRE;
            miss_run_nxt = '0;
            lock_run_nxt = '0;
          end else begin
            miss_run_nxt = miss_run + RUN_W'(1);
          end
        end else begin
          miss_run_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge MainClock) begin
    if (run_clr) begin
      KCount   <= K_MID;
      Carry    <= 1'b0;
      Borrow   <= 1'b0;
      state    <= ST_ACQUIRE;
      lock_run <= '0;
      miss_run <= '0;
    end else begin
      KCount   <= kcount_nxt;
      Carry    <= carry_nxt;
      Borrow   <= borrow_nxt;
      state    <= state_nxt;
      lock_run <= lock_run_nxt;
      miss_run <= miss_run_nxt;
    end
  end

  assign Locked = (state == ST_LOCKED);

  a_no_carry_and_borrow: assert property (@(posedge MainClock) !(Carry && Borrow));

endmodule

// File: tb/tb_kcounter_loop_filter.sv
// Bench for kcounter_loop_filter: directed spec scenarios with literal expectations, then randomized
// traffic checked every cycle against a behavioural model.
module tb_kcounter_loop_filter;

  localparam int KW  = 4;
  localparam int KM  = 8;
  localparam int LC  = 8;
  localparam int ULC = 4;

  logic          MainClock = 1'b0;
  logic          ResetN = 1'b0;
  logic          Enable = 1'b0;
  logic          Lead = 1'b0;
  logic          Lag = 1'b0;
  logic          Lock = 1'b0;
  logic          InputSignalEdge = 1'b0;
  logic          Carry;
  logic          Borrow;
  logic          Locked;
  logic [KW-1:0] KCount;

  kcounter_loop_filter #(.KWIDTH(KW), .LOCK_CNT(LC), .UNLOCK_CNT(ULC)) dut (
    .MainClock(MainClock), .ResetN(ResetN), .Enable(Enable), .Lead(Lead), .Lag(Lag),
    .Lock(Lock), .InputSignalEdge(InputSignalEdge), .Carry(Carry), .Borrow(Borrow),
    .Locked(Locked), .KCount(KCount)
  );

  always #5 MainClock = ~MainClock;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Behavioural model: counter value, pulses, lock flag and run lengths as plain integers.
  int m_k = KM;
  bit m_c = 0;
  bit m_b = 0;
  bit m_locked = 0;
  int m_hits = 0;
  int m_miss = 0;

  always @(posedge MainClock) begin
    if (!ResetN || !Enable) begin
      m_k = KM; m_c = 0; m_b = 0; m_locked = 0; m_hits = 0; m_miss = 0;
    end else begin
      m_c = 0; m_b = 0;
      if (Lag && !Lead) begin
        if (m_k == (1 << KW) - 1) begin m_k = KM; m_c = 1; end
        else m_k = m_k + 1;
      end else if (Lead && !Lag) begin
        if (m_k == 0) begin m_k = KM; m_b = 1; end
        else m_k = m_k - 1;
      end
      if (InputSignalEdge) begin
        if (!m_locked) begin
          m_hits = Lock ? m_hits + 1 : 0;
          if (m_hits == LC) begin m_locked = 1; m_hits = 0; m_miss = 0; end
        end else begin
          m_miss = Lock ? 0 : m_miss + 1;
          if (m_miss == ULC) begin m_locked = 0; m_miss = 0; m_hits = 0; end
        end
      end
    end
  end

  always @(negedge MainClock) begin
    if (chk_on) begin
      n_checks += 4;
      if (int'(KCount) !== m_k) begin
        n_fail++; $display("FAIL model_kcount t=%0t dut=%0d model=%0d", $time, KCount, m_k);
      end
      if (Carry !== m_c) begin
        n_fail++; $display("FAIL model_carry t=%0t dut=%b model=%b", $time, Carry, m_c);
      end
      if (Borrow !== m_b) begin
        n_fail++; $display("FAIL model_borrow t=%0t dut=%b model=%b", $time, Borrow, m_b);
      end
      if (Locked !== m_locked) begin
        n_fail++; $display("FAIL model_locked t=%0t dut=%b model=%b", $time, Locked, m_locked);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t dut=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs; returns at the following negedge with outputs settled.
  task automatic step(input bit rn, input bit en, input bit ld, input bit lg,
                      input bit lk, input bit se);
    ResetN = rn; Enable = en; Lead = ld; Lag = lg; Lock = lk; InputSignalEdge = se;
    @(negedge MainClock);
  endtask

  task automatic idle();
    step(1, 1, 0, 0, 0, 0);
  endtask

  task automatic strobe(input bit lk);
    step(1, 1, 0, 0, lk, 1);
  endtask

  initial begin
    @(negedge MainClock);
    // 1. reset and idle
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk_on = 1'b1;
    lit("rst_kcount", int'(KCount), 8);
    lit("rst_carry", int'(Carry), 0);
    lit("rst_borrow", int'(Borrow), 0);
    lit("rst_locked", int'(Locked), 0);
    repeat (3) idle();
    lit("idle_kcount", int'(KCount), 8);

    // 2. carry path
    repeat (7) step(1, 1, 0, 1, 0, 0);
    lit("lag7_kcount", int'(KCount), 15);
    lit("lag7_carry", int'(Carry), 0);
    step(1, 1, 0, 1, 0, 0);
    lit("carry_pulse", int'(Carry), 1);
    lit("carry_reload", int'(KCount), 8);
    idle();
    lit("carry_one_cycle", int'(Carry), 0);

    // 3. borrow path and conflicting pulses
    repeat (8) step(1, 1, 1, 0, 0, 0);
    lit("lead8_kcount", int'(KCount), 0);
    lit("lead8_borrow", int'(Borrow), 0);
    step(1, 1, 1, 0, 0, 0);
    lit("borrow_pulse", int'(Borrow), 1);
    lit("borrow_reload", int'(KCount), 8);
    idle();
    lit("borrow_one_cycle", int'(Borrow), 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    lit("both_hold", int'(KCount), 9);
    lit("both_no_carry", int'(Carry), 0);
    lit("both_no_borrow", int'(Borrow), 0);

    // 4. lock entry, with an interrupted run
    repeat (7) strobe(1);
    lit("lock7_locked", int'(Locked), 0);
    idle();
    lit("lock_gap_hold", int'(Locked), 0);
    strobe(1);
    lit("lock8_locked", int'(Locked), 1);
    step(0, 1, 0, 0, 0, 0);
    repeat (4) strobe(1);
    strobe(0);
    repeat (7) strobe(1);
    lit("relock7_locked", int'(Locked), 0);
    strobe(1);
    lit("relock8_locked", int'(Locked), 1);

    // 5. lock loss
    repeat (3) strobe(0);
    strobe(1);
    lit("miss3_locked", int'(Locked), 1);
    repeat (3) strobe(0);
    lit("miss3b_locked", int'(Locked), 1);
    strobe(0);
    lit("miss4_unlocked", int'(Locked), 0);

    // 6. mid-operation abort, via reset then via enable
    for (int v = 0; v < 2; v++) begin
      step(0, 1, 0, 0, 0, 0);
      repeat (5) step(1, 1, 0, 1, 1, 1);
      lit("abort_pre_kcount", int'(KCount), 13);
      if (v == 0) step(0, 1, 0, 1, 1, 1);
      else        step(1, 0, 0, 1, 1, 1);
      lit("abort_kcount", int'(KCount), 8);
      lit("abort_locked", int'(Locked), 0);
      repeat (7) strobe(1);
      lit("abort_relock7", int'(Locked), 0);
      strobe(1);
      lit("abort_relock8", int'(Locked), 1);
    end

    // Randomized traffic; lock quality alternates between good and poor epochs.
    for (int e = 0; e < 20; e++) begin
      int good_pct;
      good_pct = (e % 2 == 0) ? 95 : 30;
      for (int i = 0; i < 200; i++) begin
        bit rn, en, ld, lg, lk, se;
        rn = ($urandom_range(0, 299) != 0);
        en = ($urandom_range(0, 199) != 0);
        ld = ($urandom_range(0, 2) == 0);
        lg = ($urandom_range(0, 2) == 0);
        lk = ($urandom_range(0, 99) < good_pct);
        se = ($urandom_range(0, 2) == 0);
        step(rn, en, ld, lg, lk, se);
      end
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
